// File: rtl/lilypad_home_renderer.sv
// Home-row lilypad renderer.
// Two-stage pixel pipeline that maps the scan coordinate onto one of the home
// lilypads and looks up the sprite palette index. It also owns the per-pad
// "frog home" occupancy and the end-of-round flash/clear sequence.
module lilypad_home_renderer #(
  parameter int NUM_PADS        = 5,
  parameter int PAD_SIZE        = 40,
  parameter int PAD_Y           = 40,
  parameter int PAD_X0          = 40,
  parameter int PAD_PITCH       = 120,
  parameter int TRANSPARENT_IDX = 0,
  parameter int OCC_IDX         = 12,
  parameter int FLASH_FRAMES    = 32
) (
  input  logic                                   Clk,
  input  logic                                   Reset_n,
  input  logic                                   frame_start,
  input  logic                                   pixel_valid,
  input  logic [9:0]                             DrawX,
  input  logic [9:0]                             DrawY,
  input  logic [0:PAD_SIZE-1][0:PAD_SIZE-1][4:0] sprite_rgb,
  input  logic                                   frog_home_valid,
  input  logic [2:0]                             frog_home_slot,
  input  logic                                   clear_all,
  output logic                                   pix_valid,
  output logic                                   pix_hit,
  output logic [4:0]                             pix_idx,
  output logic [NUM_PADS-1:0]                    occupied,
  output logic                                   home_reject,
  output logic                                   round_done
);

  // Flash counter must be wide enough for FLASH_FRAMES-1 and expose bit 2.
  localparam int FC_W = (FLASH_FRAMES > 8) ? $clog2(FLASH_FRAMES) : 3;
  localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_FRAMES - 1);

  localparam logic [4:0] TRANSP   = 5'(TRANSPARENT_IDX);
  localparam logic [4:0] OCC_PAL  = 5'(OCC_IDX);
  localparam logic [10:0] ROW_TOP = 11'(PAD_Y);
  localparam logic [10:0] ROW_END = 11'(PAD_Y + PAD_SIZE);

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_FLASH = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // Game state
  logic [1:0]          state_reg;
  logic [FC_W-1:0]     flash_cnt_reg;
  logic [NUM_PADS-1:0] occ_reg;
  logic                home_reject_reg;
  logic                round_done_reg;

  // Stage 1 registers
  logic       s1_valid_reg;
  logic       s1_in_pad_reg;
  logic [5:0] s1_lx_reg;
  logic [5:0] s1_ly_reg;
  logic       s1_force_occ_reg;

  // Stage 2 (output) registers
  logic       pix_valid_reg;
  logic       pix_hit_reg;
  logic [4:0] pix_idx_reg;

  // Address decode (combinational, feeds S1)
  logic                row_hit;
  logic [5:0]          row_ly;
  logic [NUM_PADS-1:0] pad_hit;
  logic [5:0]          pad_lx [NUM_PADS];
  logic [5:0]          sel_lx;
  logic                in_pad;
  logic                occ_hit;
  logic                force_occ;

  assign row_hit = ({1'b0, DrawY} >= ROW_TOP) && ({1'b0, DrawY} < ROW_END);
  assign row_ly  = row_hit ? 6'(DrawY - ROW_TOP[9:0]) : 6'd0;

  // One window comparator per pad; pad edges are elaboration-time constants.
  generate
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      localparam logic [10:0] LEFT  = 11'(PAD_X0 + gi * PAD_PITCH);
      localparam logic [10:0] RIGHT = 11'(PAD_X0 + gi * PAD_PITCH + PAD_SIZE);
      assign pad_hit[gi] = row_hit && ({1'b0, DrawX} >= LEFT) && ({1'b0, DrawX} < RIGHT);
      assign pad_lx[gi]  = 6'(DrawX - LEFT[9:0]);
    end
  endgenerate

  // Select the local column of whichever pad window matched (pads never overlap).
  always_comb begin
    sel_lx = 6'd0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (pad_hit[i]) sel_lx = pad_lx[i];
    end
  end

  assign in_pad    = |pad_hit;
  assign occ_hit   = |(pad_hit & occ_reg);
  assign force_occ = ((state_reg == ST_PLAY) && occ_hit) ||
                     ((state_reg == ST_FLASH) && flash_cnt_reg[2]);

  // Home-request slot decode; slots beyond the last pad decode to an empty mask.
  logic [NUM_PADS-1:0] slot_mask;
  logic                slot_free;

  always_comb begin
    slot_mask = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      slot_mask[i] = (frog_home_slot == 3'(i));
    end
  end

  assign slot_free = |(slot_mask & ~occ_reg);

  // Sprite lookup and palette override for stage 2.
  logic [4:0] s2_idx;
  logic       s2_hit;
  logic [4:0] s2_out_idx;

  assign s2_idx     = sprite_rgb[s1_ly_reg][s1_lx_reg];
  assign s2_hit     = s1_valid_reg && s1_in_pad_reg && (s2_idx != TRANSP);
  assign s2_out_idx = !s2_hit ? 5'd0 : (s1_force_occ_reg ? OCC_PAL : s2_idx);

  // Pixel pipeline: S1 captures decode + state snapshot, S2 registers the result.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_reg     <= 1'b0;
      s1_in_pad_reg    <= 1'b0;
      s1_lx_reg        <= 6'd0;
      s1_ly_reg        <= 6'd0;
      s1_force_occ_reg <= 1'b0;
      pix_valid_reg    <= 1'b0;
      pix_hit_reg      <= 1'b0;
      pix_idx_reg      <= 5'd0;
    end else begin
      s1_valid_reg     <= pixel_valid;
      s1_in_pad_reg    <= in_pad;
      s1_lx_reg        <= sel_lx;
      s1_ly_reg        <= row_ly;
      s1_force_occ_reg <= force_occ;
      pix_valid_reg    <= s1_valid_reg;
      pix_hit_reg      <= s2_hit;
      pix_idx_reg      <= s2_out_idx;
    end
  end

  // Occupancy and round FSM: PLAY fills pads, FLASH counts frames, CLEAR empties.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg       <= ST_PLAY;
      flash_cnt_reg   <= '0;
      occ_reg         <= '0;
      home_reject_reg <= 1'b0;
      round_done_reg  <= 1'b0;
    end else begin
      home_reject_reg <= 1'b0;
      round_done_reg  <= 1'b0;
      if (clear_all) begin
        occ_reg       <= '0;
        flash_cnt_reg <= '0;
        state_reg     <= ST_PLAY;
      end else begin
        case (state_reg)
          ST_PLAY: begin
            if (frog_home_valid) begin
              if (slot_free) occ_reg <= occ_reg | slot_mask;
              else           home_reject_reg <= 1'b1;
            end
            if (&occ_reg) begin
              state_reg     <= ST_FLASH;
              flash_cnt_reg <= '0;
            end
          end
          ST_FLASH: begin
            if (frog_home_valid) home_reject_reg <= 1'b1;
            if (frame_start) begin
              if (flash_cnt_reg == FLASH_LAST) begin
                state_reg     <= ST_CLEAR;
                flash_cnt_reg <= '0;
              end else begin
                flash_cnt_reg <= flash_cnt_reg + 1'b1;
              end
            end
          end
          ST_CLEAR: begin
            if (frog_home_valid) home_reject_reg <= 1'b1;
            occ_reg        <= '0;
            round_done_reg <= 1'b1;
            state_reg      <= ST_PLAY;
          end
          default: state_reg <= ST_PLAY;
        endcase
      end
    end
  end

  assign pix_valid   = pix_valid_reg;
  assign pix_hit     = pix_hit_reg;
  assign pix_idx     = pix_idx_reg;
  assign occupied    = occ_reg;
  assign home_reject = home_reject_reg;
  assign round_done  = round_done_reg;

endmodule

// File: tb/tb_lilypad_home_renderer.sv
// Self-checking bench for lilypad_home_renderer: table vectors, hand-written
// FSM sequences, and randomized pixel streams against a behavioural model.
module tb_lilypad_home_renderer;

  logic                         Clk = 1'b0;
  logic                         Reset_n;
  logic                         frame_start;
  logic                         pixel_valid;
  logic [9:0]                   DrawX;
  logic [9:0]                   DrawY;
  logic [0:39][0:39][4:0]       sprite_rgb;
  logic                         frog_home_valid;
  logic [2:0]                   frog_home_slot;
  logic                         clear_all;
  logic                         pix_valid;
  logic                         pix_hit;
  logic [4:0]                   pix_idx;
  logic [4:0]                   occupied;
  logic                         home_reject;
  logic                         round_done;

  lilypad_home_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .DrawX(DrawX), .DrawY(DrawY),
    .sprite_rgb(sprite_rgb), .frog_home_valid(frog_home_valid),
    .frog_home_slot(frog_home_slot), .clear_all(clear_all),
    .pix_valid(pix_valid), .pix_hit(pix_hit), .pix_idx(pix_idx),
    .occupied(occupied), .home_reject(home_reject), .round_done(round_done)
  );

  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural game model
  logic [4:0] m_occ    = 5'd0;
  bit         m_flash  = 1'b0;
  int         m_frames = 0;

  typedef struct {
    int         x;
    int         y;
    bit         hit;
    logic [4:0] idx;
    string      name;
  } vec_t;

  typedef struct {
    bit         v;
    bit         hit;
    logic [4:0] idx;
  } exp_t;

  vec_t vecs[14];

  // Expected pixel result from plain geometry: pad = (x-40)/120, column = remainder.
  function automatic exp_t model_pix(input bit v, input int x, input int y);
    exp_t       e;
    int         p;
    int         off;
    logic [4:0] s;
    e.v = v; e.hit = 1'b0; e.idx = 5'd0;
    if (!v || y < 40 || y >= 80 || x < 40) return e;
    p   = (x - 40) / 120;
    off = (x - 40) % 120;
    if (p >= 5 || off >= 40) return e;
    s = sprite_rgb[y - 40][off];
    if (s == 5'd0) return e;
    e.hit = 1'b1;
    if ((!m_flash && m_occ[p]) || (m_flash && ((m_frames / 4) % 2 == 1))) e.idx = 5'd12;
    else e.idx = s;
    return e;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input bit eh, input logic [4:0] ei, input string name);
    pixel_valid = 1'b1; DrawX = 10'(x); DrawY = 10'(y);
    step();
    pixel_valid = 1'b0;
    step();
    check({name, "_valid"}, int'(pix_valid), 1);
    check({name, "_hit"}, int'(pix_hit), int'(eh));
    check({name, "_idx"}, int'(pix_idx), int'(ei));
    $display("pixel %s x=%0d y=%0d hit=%0d idx=%0d", name, x, y, pix_hit, pix_idx);
  endtask

  task automatic pix_model(input int x, input int y, input string name);
    exp_t e;
    e = model_pix(1'b1, x, y);
    pix(x, y, e.hit, e.idx, name);
  endtask

  task automatic home(input int slot, input string name);
    bit rej;
    rej = m_flash || (slot >= 5) || m_occ[slot % 5];
    if (!rej) m_occ[slot] = 1'b1;
    frog_home_valid = 1'b1; frog_home_slot = 3'(slot);
    step();
    frog_home_valid = 1'b0;
    check({name, "_reject"}, int'(home_reject), int'(rej));
    check({name, "_occ"}, int'(occupied), int'(m_occ));
    $display("home %s slot=%0d reject=%0d occupied=%b", name, slot, home_reject, occupied);
  endtask

  task automatic frame(input string name);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_frames++;
    check({name, "_no_done"}, int'(round_done), 0);
  endtask

  task automatic stream(input int n, input string name);
    exp_t q[$];
    exp_t e;
    int   x;
    int   y;
    bit   v;
    int   xe[12] = '{39, 40, 79, 80, 159, 160, 199, 200, 519, 520, 559, 560};
    int   ye[4]  = '{39, 40, 79, 80};
    for (int i = 0; i < n + 2; i++) begin
      v = (i < n) && ($urandom_range(0, 3) != 0);
      x = $urandom_range(0, 639);
      y = $urandom_range(30, 90);
      if ($urandom_range(0, 5) == 0) x = xe[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) y = ye[$urandom_range(0, 3)];
      pixel_valid = v; DrawX = 10'(x); DrawY = 10'(y);
      q.push_back(model_pix(v, x, y));
      step();
      if (i >= 1) begin
        e = q.pop_front();
        n_cmp++;
        if (pix_valid !== e.v || pix_hit !== e.hit || pix_idx !== e.idx) begin
          n_fail++;
          $display("FAIL stream_%s[%0d]: got v=%0d hit=%0d idx=%0d want v=%0d hit=%0d idx=%0d",
                   name, i - 1, pix_valid, pix_hit, pix_idx, e.v, e.hit, e.idx);
        end else begin
          $display("stream %s[%0d] v=%0d hit=%0d idx=%0d", name, i - 1, pix_valid, pix_hit, pix_idx);
        end
      end
    end
    pixel_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    Reset_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; frog_home_valid = 1'b0;
    frog_home_slot = 3'd0; clear_all = 1'b0;

    // Random sprite with pinned pixels used by the directed vectors.
    for (int r = 0; r < 40; r++)
      for (int c = 0; c < 40; c++)
        sprite_rgb[r][c] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    sprite_rgb[0][0]   = 5'd0;
    sprite_rgb[2][20]  = 5'd10;
    sprite_rgb[19][17] = 5'd10;
    sprite_rgb[19][18] = 5'd0;
    sprite_rgb[20][39] = 5'd7;
    sprite_rgb[2][0]   = 5'd17;
    sprite_rgb[39][39] = 5'd31;

    vecs[0]  = '{60, 42, 1'b1, 5'd10, "first"};
    vecs[1]  = '{40, 40, 1'b0, 5'd0, "transp00"};
    vecs[2]  = '{57, 59, 1'b1, 5'd10, "opaque57"};
    vecs[3]  = '{58, 59, 1'b0, 5'd0, "transp58"};
    vecs[4]  = '{79, 60, 1'b1, 5'd7, "pad0_right"};
    vecs[5]  = '{80, 60, 1'b0, 5'd0, "pad0_past"};
    vecs[6]  = '{180, 42, 1'b1, 5'd10, "pad1"};
    vecs[7]  = '{60, 80, 1'b0, 5'd0, "row_below"};
    vecs[8]  = '{60, 39, 1'b0, 5'd0, "row_above"};
    vecs[9]  = '{519, 42, 1'b0, 5'd0, "pad4_before"};
    vecs[10] = '{520, 42, 1'b1, 5'd17, "pad4_left_msb"};
    vecs[11] = '{559, 79, 1'b1, 5'd31, "pad4_corner"};
    vecs[12] = '{560, 42, 1'b0, 5'd0, "pad4_past"};
    vecs[13] = '{1023, 1023, 1'b0, 5'd0, "far_corner"};

    // Reset state
    step(); step(); step();
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_pix_hit", int'(pix_hit), 0);
    check("rst_pix_idx", int'(pix_idx), 0);
    check("rst_occupied", int'(occupied), 0);
    check("rst_home_reject", int'(home_reject), 0);
    check("rst_round_done", int'(round_done), 0);
    Reset_n = 1'b1;
    step();
    check("post_rst_pix_valid", int'(pix_valid), 0);

    // Directed pixel table
    for (int i = 0; i < 14; i++) pix(vecs[i].x, vecs[i].y, vecs[i].hit, vecs[i].idx, vecs[i].name);

    // Occupancy in PLAY
    home(2, "slot2");
    pix(300, 42, 1'b1, 5'd12, "slot2_occ_pix");
    pix(180, 42, 1'b1, 5'd10, "slot1_free_pix");
    home(2, "slot2_again");
    home(6, "slot6");
    home(7, "slot7");
    stream(300, "play");

    // Fill remaining pads and enter FLASH
    home(0, "fill0");
    home(1, "fill1");
    home(3, "fill3");
    home(4, "fill4");
    step();
    m_flash = 1'b1; m_frames = 0;
    pix_model(60, 42, "flash_ph0");
    pix(40, 40, 1'b0, 5'd0, "flash_transp");
    home(1, "flash_reject");
    for (int f = 0; f < 4; f++) frame("flash_a");
    pix_model(60, 42, "flash_ph1");
    stream(60, "flash_ph1");
    for (int f = 0; f < 4; f++) frame("flash_b");
    pix_model(60, 42, "flash_ph0b");
    while (m_frames < 32) frame("flash_c");
    check("clear_cycle_occ", int'(occupied), 31);
    step();
    check("round_done_pulse", int'(round_done), 1);
    check("round_occ_cleared", int'(occupied), 0);
    m_flash = 1'b0; m_occ = 5'd0; m_frames = 0;
    step();
    check("round_done_single", int'(round_done), 0);
    home(0, "after_round_slot0");

    // clear_all mid-FLASH with a same-cycle home request
    home(1, "refill1");
    home(2, "refill2");
    home(3, "refill3");
    home(4, "refill4");
    step();
    m_flash = 1'b1; m_frames = 0;
    for (int f = 0; f < 5; f++) frame("pre_clear");
    clear_all = 1'b1; frog_home_valid = 1'b1; frog_home_slot = 3'd1;
    step();
    clear_all = 1'b0; frog_home_valid = 1'b0;
    m_flash = 1'b0; m_occ = 5'd0; m_frames = 0;
    check("clear_all_occ", int'(occupied), 0);
    check("clear_all_no_reject", int'(home_reject), 0);
    check("clear_all_no_done", int'(round_done), 0);
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      frame_start = (c % 2 == 0);
      step();
      if (round_done) done_cnt++;
    end
    frame_start = 1'b0;
    check("clear_all_no_late_done", done_cnt, 0);
    pix_model(60, 42, "clear_all_play_pix");
    home(3, "clear_all_slot3");

    // Reset during FLASH with a pixel in flight
    home(0, "rfill0");
    home(1, "rfill1");
    home(2, "rfill2");
    home(4, "rfill4");
    step();
    m_flash = 1'b1; m_frames = 0;
    frame("pre_reset");
    pixel_valid = 1'b1; DrawX = 10'd60; DrawY = 10'd42;
    step();
    Reset_n = 1'b0;
    step();
    check("mid_rst_pix_valid", int'(pix_valid), 0);
    check("mid_rst_pix_hit", int'(pix_hit), 0);
    check("mid_rst_pix_idx", int'(pix_idx), 0);
    check("mid_rst_occupied", int'(occupied), 0);
    check("mid_rst_home_reject", int'(home_reject), 0);
    check("mid_rst_round_done", int'(round_done), 0);
    Reset_n = 1'b1; pixel_valid = 1'b0;
    m_flash = 1'b0; m_occ = 5'd0; m_frames = 0;
    step();
    check("rel_pix_valid_1", int'(pix_valid), 0);
    step();
    check("rel_pix_valid_2", int'(pix_valid), 0);
    pix_model(60, 42, "post_reset_pix");
    home(2, "post_reset_slot2");
    pix(300, 42, 1'b1, 5'd12, "post_reset_occ_pix");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lilypad_home_renderer.md
Name: lilypad_home_renderer

Overview:
- Pixel-pipeline stage directly downstream of the 40x40 lilypad sprite ROM.
- Takes the VGA scan coordinate and the sprite palette-index array. Decides whether the current pixel falls on one of the home-row lilypads and emits the palette index to the colour mapper.
- Owns the per-pad "frog home" occupancy state and the round-complete flash sequence.

Parameters:
NUM_PADS, 5, number of home lilypads (max 8)
PAD_SIZE, 40, sprite width/height in pixels
PAD_Y, 40, top row of the home lilypads
PAD_X0, 40, left column of pad 0
PAD_PITCH, 120, horizontal distance between pad left edges
TRANSPARENT_IDX, 0, palette index treated as transparent
OCC_IDX, 12, palette index drawn over an occupied pad
FLASH_FRAMES, 32, frames spent in FLASH before auto-clear

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse at start of each frame
pixel_valid  in  1  DrawX/DrawY valid this cycle
DrawX  in  10  scan column
DrawY  in  10  scan row
sprite_rgb  in  [0:39][0:39] x 5  palette-index array from the sprite ROM, [row][col]
frog_home_valid  in  1  frog reached a home slot this cycle
frog_home_slot  in  3  slot index for frog_home_valid
clear_all  in  1  game reset/level restart; empties all pads
pix_valid  out  1  pipelined pixel_valid
pix_hit  out  1  pixel is an opaque lilypad pixel
pix_idx  out  5  palette index (0 when !pix_hit)
occupied  out  NUM_PADS  per-pad occupancy
home_reject  out  1  pulse: home request ignored
round_done  out  1  pulse: all pads filled and flash finished

Behaviour:
- Reset (Reset_n=0 at Clk edge):
  - pix_valid, pix_hit, pix_idx, occupied, home_reject, round_done all 0.
  - FSM enters PLAY; flash_cnt=0.
  - Pipeline contents discarded; pix_valid is 0 on the first post-reset cycle.
- Pipeline, latency exactly 2 cycles; one pixel per cycle; no stall.
  - S1 registers:
    - pixel_valid.
    - row_hit = PAD_Y <= DrawY < PAD_Y+PAD_SIZE.
    - Slot k, the unique k < NUM_PADS with PAD_X0+k*PAD_PITCH <= DrawX < that value +PAD_SIZE; in_pad = row_hit and such k exists.
    - lx = DrawX-left_k, ly = DrawY-PAD_Y (6 bits each).
    - Snapshot of occupied[k], FSM state and flash phase.
  - S2:
    - idx = sprite_rgb[ly][lx].
    - pix_hit = S1.valid & in_pad & (idx != TRANSPARENT_IDX).
    - pix_idx:
      - 0 if !pix_hit.
      - Else OCC_IDX if PLAY and occupied[k].
      - Else OCC_IDX if FLASH and flash_cnt[2]=1.
      - Else idx.
  - pix_valid = S1.valid.
- Address arithmetic: 10-bit unsigned. Pad slot compare uses constants computed at elaboration; no multiplier in the datapath. Pixels with DrawX/DrawY at or beyond any edge produce in_pad=0.
- Occupancy (PLAY only):
  - frog_home_valid with slot < NUM_PADS and !occupied[slot]: occupied[slot] is set on the next edge.
  - Slot >= NUM_PADS or already occupied: no change; home_reject=1 for one cycle.
- FSM:
  - PLAY: when occupied becomes all-ones, go to FLASH on the following edge with flash_cnt=0.
  - FLASH:
    - flash_cnt increments on each frame_start.
    - When frame_start arrives with flash_cnt=FLASH_FRAMES-1, go to CLEAR.
    - frog_home_valid is rejected (home_reject pulse).
  - CLEAR: single cycle. occupied<=0, round_done=1, then PLAY.
- clear_all: from any state, next edge gives occupied=0, flash_cnt=0, state PLAY; no round_done. clear_all wins over a same-cycle frog_home_valid; no home_reject is issued for that request.
- Simultaneous frame_start and frog_home_valid in PLAY: both honoured; the new occupancy is visible to pixels entering S1 on the following cycle.
- Occupancy changes mid-frame take effect immediately at pixel granularity. No frame double-buffering.
- Sprite MSB (bit 4) passes through unmodified.

Test Plan:
- Reset, then pixel_valid=1, DrawX=60, DrawY=42 -> two cycles later pix_valid=1, pix_hit=1, pix_idx=10.
- Transparency: DrawX=40, DrawY=40 (sprite[0][0]=0) -> pix_hit=0, pix_idx=0. DrawX=57, DrawY=59 -> hit, idx 10. DrawX=58, DrawY=59 -> no hit.
- Pad bounds: DrawX=79/80 at DrawY=60 on pad 0 -> 80 no hit. DrawX=180, DrawY=42 -> hit on pad 1. DrawY=80 -> no hit on any pad.
- frog_home_slot=2 -> occupied=5'b00100; DrawX=300, DrawY=42 -> pix_idx=12.
- Repeat slot 2 -> home_reject pulse, occupied unchanged. Slot 6 -> home_reject.
- Fill slots 0-4 -> FLASH entered. Pad pixels alternate 12 / 10 every 4 frames. After 32 frame_start pulses -> round_done single pulse, occupied=0, PLAY.
- clear_all asserted mid-FLASH with same-cycle frog_home_valid -> occupied=0, PLAY, no round_done, no home_reject.
- Reset_n low during FLASH and while pixels are in flight -> next cycle all outputs 0, state PLAY, pix_valid stays 0 for 2 cycles after Reset_n releases with pixel_valid=0.
